// File: rtl/mod_pkg.sv
// mod_pkg: shared state encoding, default widths and the configuration record for the modulation scheduler.
package mod_pkg;
    localparam int          OUTPUT_BIT_DEF = 14;
    localparam int          CNT_W_DEF      = 16;
    localparam logic [31:0] DEF_FREQ_DEF   = 32'd125;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, WAIT} state_t;

    typedef struct packed {
        logic [31:0]               freq;
        logic [OUTPUT_BIT_DEF-1:0] amp_H;
        logic [OUTPUT_BIT_DEF-1:0] amp_L;
        logic [CNT_W_DEF-1:0]      settle;
        logic [CNT_W_DEF-1:0]      win;
    } cfg_t;
endpackage

// File: rtl/mod_cfg_shadow.sv
// mod_cfg_shadow: pending/active configuration double buffer; a request applies the pending set only if one is waiting.
module mod_cfg_shadow
    import mod_pkg::*;
#(
    parameter logic [31:0] DEF_FREQ = DEF_FREQ_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      wr_i,
    input  cfg_t                      cfg_i,
    input  logic                      apply_i,
    output logic [31:0]               freq_o,
    output logic [OUTPUT_BIT_DEF-1:0] amp_h_o,
    output logic [OUTPUT_BIT_DEF-1:0] amp_l_o,
    output logic [CNT_W_DEF-1:0]      win_o,
    output logic [CNT_W_DEF-1:0]      eff_settle_o,
    output logic [CNT_W_DEF-1:0]      eff_win_o,
    output logic                      pend_o,
    output logic                      applied_o
);
    cfg_t pend_set_q, act_q;
    logic pend_q, applied_q;
    logic apply;

    assign apply = apply_i && pend_q;
    // The FSM needs the values that are active after this cycle's apply.
    assign eff_settle_o = apply ? pend_set_q.settle : act_q.settle;
    assign eff_win_o    = apply ? pend_set_q.win    : act_q.win;
    assign freq_o       = act_q.freq;
    assign amp_h_o      = act_q.amp_H;
    assign amp_l_o      = act_q.amp_L;
    assign win_o        = act_q.win;
    assign pend_o       = pend_q;
    assign applied_o    = applied_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_set_q <= '0;
            act_q      <= '{freq: DEF_FREQ, amp_H: '0, amp_L: '0, settle: '0, win: '0};
            pend_q     <= 1'b0;
            applied_q  <= 1'b0;
        end else begin
            if (wr_i) pend_set_q <= cfg_i;
            if (apply) act_q <= pend_set_q;
            pend_q    <= wr_i || (pend_q && !apply);
            applied_q <= apply;
        end
    end
endmodule

// File: rtl/mod_sched.sv
// mod_sched: applies generator configuration at full-period boundaries and times demodulation windows off status edges.
module mod_sched
    import mod_pkg::*;
#(
    parameter int          OUTPUT_BIT = OUTPUT_BIT_DEF,
    parameter logic [31:0] DEF_FREQ   = DEF_FREQ_DEF,
    parameter int          CNT_W      = CNT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_cfg_wr,
    input  logic [31:0]           i_cfg_freq,
    input  logic [OUTPUT_BIT-1:0] i_cfg_amp_H,
    input  logic [OUTPUT_BIT-1:0] i_cfg_amp_L,
    input  logic [CNT_W-1:0]      i_cfg_settle,
    input  logic [CNT_W-1:0]      i_cfg_win,
    input  logic                  i_status,
    output logic [31:0]           o_freq_cnt,
    output logic [OUTPUT_BIT-1:0] o_amp_H,
    output logic [OUTPUT_BIT-1:0] o_amp_L,
    output logic                  o_cfg_pend,
    output logic                  o_cfg_applied,
    output logic                  o_sync,
    output logic                  o_smp_en,
    output logic                  o_smp_phase,
    output logic                  o_overrun
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_win, eff_settle, eff_win;
    logic             status_q, phase_q, phase_d, sync_q, overrun_q;
    logic             stat_edge, stat_fall;
    cfg_t             cfg_in;

    assign stat_edge = i_status != status_q;
    assign stat_fall = stat_edge && !i_status;
    assign cfg_in    = '{freq: i_cfg_freq, amp_H: i_cfg_amp_H, amp_L: i_cfg_amp_L,
                         settle: i_cfg_settle, win: i_cfg_win};

    mod_cfg_shadow #(.DEF_FREQ(DEF_FREQ)) u_shadow (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .wr_i        (i_cfg_wr),
        .cfg_i       (cfg_in),
        .apply_i     (stat_fall && i_en),
        .freq_o      (o_freq_cnt),
        .amp_h_o     (o_amp_H),
        .amp_l_o     (o_amp_L),
        .win_o       (act_win),
        .eff_settle_o(eff_settle),
        .eff_win_o   (eff_win),
        .pend_o      (o_cfg_pend),
        .applied_o   (o_cfg_applied)
    );

    assign o_sync      = sync_q;
    assign o_smp_en    = state_q == SAMPLE;
    assign o_smp_phase = phase_q;
    assign o_overrun   = overrun_q;

    // A zero settle skips SETTLE so the strobe starts right after the edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(cnt_q != '0);
        phase_d = phase_q;
        if (!i_en) begin
            state_d = IDLE;
        end else if (stat_edge) begin
            phase_d = i_status;
            state_d = eff_settle != '0 ? SETTLE : eff_win != '0 ? SAMPLE : WAIT;
            cnt_d   = eff_settle != '0 ? eff_settle : eff_win;
        end else if (state_q == SETTLE && cnt_q <= CNT_W'(1)) begin
            state_d = act_win != '0 ? SAMPLE : WAIT;
            cnt_d   = act_win;
        end else if (state_q == SAMPLE && cnt_q <= CNT_W'(1)) begin
            state_d = WAIT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            status_q  <= 1'b0;
            phase_q   <= 1'b0;
            sync_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            status_q  <= i_status;
            phase_q   <= phase_d;
            sync_q    <= stat_edge;
            overrun_q <= i_en && stat_edge && state_q == SAMPLE;
        end
    end
endmodule

// File: tb/tb_mod_sched.sv
// tb_mod_sched: randomized and directed stimulus; a window/period reference model feeds a per-cycle scoreboard.
module tb_mod_sched;
    localparam int OB = 14;
    localparam int CW = 16;

    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, wr = 1'b0, st = 1'b0;
    logic [31:0]   c_freq = '0;
    logic [OB-1:0] c_ah = '0, c_al = '0;
    logic [CW-1:0] c_settle = '0, c_win = '0;
    logic [31:0]   o_freq_cnt;
    logic [OB-1:0] o_amp_H, o_amp_L;
    logic          o_cfg_pend, o_cfg_applied, o_sync, o_smp_en, o_smp_phase, o_overrun;
    bit            n_st = 1'b0, n_en = 1'b0;

    mod_sched dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cfg_wr(wr), .i_cfg_freq(c_freq),
        .i_cfg_amp_H(c_ah), .i_cfg_amp_L(c_al), .i_cfg_settle(c_settle), .i_cfg_win(c_win),
        .i_status(st), .o_freq_cnt(o_freq_cnt), .o_amp_H(o_amp_H), .o_amp_L(o_amp_L),
        .o_cfg_pend(o_cfg_pend), .o_cfg_applied(o_cfg_applied), .o_sync(o_sync),
        .o_smp_en(o_smp_en), .o_smp_phase(o_smp_phase), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sync, applied, overrun, smp, phase, pend;
        logic [31:0]   freq;
        logic [OB-1:0] ah, al;
    } vec_t;

    vec_t q[$];
    int   errors = 0, checks = 0;

    // Reference model: windows are cycle intervals [ws, we] computed from the last edge.
    int            n, ws, we;
    bit            m_stp, m_pend, m_run, m_phase, m_smp;
    logic [31:0]   p_freq, a_freq;
    logic [OB-1:0] p_ah, p_al, a_ah, a_al;
    int            p_set, p_win, a_set, a_win;

    function automatic void model_reset();
        n = 0; ws = 0; we = -1;
        m_stp = 0; m_pend = 0; m_run = 0; m_phase = 0; m_smp = 0;
        p_freq = '0; p_ah = '0; p_al = '0; p_set = 0; p_win = 0;
        a_freq = 32'd125; a_ah = '0; a_al = '0; a_set = 0; a_win = 0;
        q.delete();
    endfunction

    function automatic void model_step();
        bit   e, f, ap;
        vec_t v;
        e  = st != m_stp;
        f  = e && !st;
        ap = f && m_pend && en;
        v.overrun = e && en && m_smp;
        if (ap) begin
            a_freq = p_freq; a_ah = p_ah; a_al = p_al; a_set = p_set; a_win = p_win;
        end
        if (wr) begin
            p_freq = c_freq; p_ah = c_ah; p_al = c_al; p_set = int'(c_settle); p_win = int'(c_win);
            m_pend = 1;
        end else if (ap) m_pend = 0;
        if (!en) m_run = 0;
        else if (e) begin
            m_run = 1; m_phase = st;
            ws = n + 1 + a_set;
            we = n + a_set + a_win;
        end
        m_stp = st;
        m_smp = m_run && (n + 1 >= ws) && (n + 1 <= we);
        v.sync = e; v.applied = ap; v.smp = m_smp; v.phase = m_phase; v.pend = m_pend;
        v.freq = a_freq; v.ah = a_ah; v.al = a_al;
        q.push_back(v);
        n++;
    endfunction

    task automatic tick(input bit w, input int f, input int h, input int l, input int s, input int wn);
        @(negedge clk);
        st = n_st; en = n_en; wr = w;
        if (w) begin
            c_freq = 32'(f); c_ah = OB'(h); c_al = OB'(l); c_settle = CW'(s); c_win = CW'(wn);
        end
        @(posedge clk);
        model_step();
    endtask

    task automatic cyc();
        tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic run(input int k);
        repeat (k) cyc();
    endtask

    task automatic half(input int k);
        run(k);
        n_st = !n_st;
    endtask

    task automatic to_high();
        if (!n_st) half(125);
    endtask

    always @(negedge clk) begin
        if (rst_n && q.size() != 0) begin
            vec_t e, a;
            e = q.pop_front();
            a = {o_sync, o_cfg_applied, o_overrun, o_smp_en, o_smp_phase, o_cfg_pend,
                 o_freq_cnt, o_amp_H, o_amp_L};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t: got sync/app/ovr/smp/ph/pend=%b%b%b%b%b%b freq=%0d H=%0d L=%0d, want %b%b%b%b%b%b freq=%0d H=%0d L=%0d",
                         $time, a.sync, a.applied, a.overrun, a.smp, a.phase, a.pend, a.freq, a.ah, a.al,
                         e.sync, e.applied, e.overrun, e.smp, e.phase, e.pend, e.freq, e.ah, e.al);
            end
        end
    end

    task automatic check_rst();
        vec_t a, r;
        r = '0;
        r.freq = 32'd125;
        a = {o_sync, o_cfg_applied, o_overrun, o_smp_en, o_smp_phase, o_cfg_pend,
             o_freq_cnt, o_amp_H, o_amp_L};
        checks++;
        if (a !== r) begin
            errors++;
            $display("FAIL reset_values t=%0t: got %h, want %h", $time, a, r);
        end
    endtask

    initial begin
        int k;
        model_reset();
        #12 check_rst();
        @(negedge clk); #2 rst_n = 1'b1;
        n_en = 1;
        run(5);
        repeat (4) half(125);
        // Mid-HIGH write, then observe application at the fall.
        to_high();
        run(60);
        tick(1, 200, 3000, -3000, 10, 50);
        run(64);
        n_st = !n_st;
        repeat (3) half(125);
        // Two writes before one fall: last wins.
        to_high();
        run(20);
        tick(1, 200, 100, -5, 10, 50);
        run(20);
        tick(1, 200, 200, -5, 10, 50);
        run(83);
        n_st = !n_st;
        repeat (2) half(125);
        // Write landing on the exact fall cycle.
        to_high();
        tick(1, 300, 11, -11, 3, 7);
        run(30);
        n_st = 0;
        tick(1, 400, 22, -22, 4, 9);
        run(124);
        n_st = 1;
        repeat (3) half(125);
        // Windows longer than the half-period overrun.
        to_high();
        tick(1, 125, 1000, -1000, 5, 200);
        run(50);
        n_st = !n_st;
        repeat (4) half(100);
        // Asynchronous reset inside a window.
        k = 0;
        while (!m_smp && k < 300) begin
            cyc();
            k++;
        end
        checks++;
        if (!m_smp) begin
            errors++;
            $display("FAIL reach_sample: got no window within %0d cycles, want one", k);
        end
        @(negedge clk); #2;
        rst_n = 1'b0; wr = 1'b0; st = 1'b0; n_st = 0;
        q.delete();
        #1 check_rst();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        run(30);
        repeat (3) half(60);
        // Randomized periods, writes and enable drops.
        repeat (60) begin
            int len, at;
            len = int'($urandom_range(1, 50));
            at  = int'($urandom_range(0, len - 1));
            n_en = $urandom_range(0, 7) != 0;
            run(at);
            if ($urandom_range(0, 2) == 0)
                tick(1, int'($urandom), int'($urandom), int'($urandom),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 40)));
            else cyc();
            run(len - at - 1);
            n_st = !n_st;
        end
        run(3);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mod_sched.md
# mod_sched

Scheduler and configuration controller for the gyro square-wave modulation generator. It holds the generator's period count and high/low amplitudes in shadow registers and applies host updates only at a full-period boundary, so the generator never produces a torn period. It also tracks the generator's half-period status and produces demodulation sampling windows, a boundary sync pulse and an overrun flag for the downstream ADC accumulator.

## Interface
- OUTPUT_BIT, 14: amplitude width, matching the generator.
- DEF_FREQ, 125: reset and idle value of o_freq_cnt.
- CNT_W, 16: width of the settle and window counters.
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_en  in  1  scheduler enable. Low forces IDLE.
- i_cfg_wr  in  1  one-cycle pulse; loads all i_cfg_* fields into the pending set.
- i_cfg_freq  in  32  half-period count for the generator.
- i_cfg_amp_H, i_cfg_amp_L  in  OUTPUT_BIT  amplitudes, two's complement.
- i_cfg_settle  in  CNT_W  cycles to ignore after each edge.
- i_cfg_win  in  CNT_W  sample-window length; 0 disables sampling.
- i_status  in  1  generator half-period status (1 = HIGH half).
- o_freq_cnt  out  32  active value driven to the generator.
- o_amp_H, o_amp_L  out  OUTPUT_BIT  active amplitudes driven to the generator.
- o_cfg_pend  out  1  a pending set is waiting to be applied.
- o_cfg_applied  out  1  one-cycle pulse when the pending set becomes active.
- o_sync  out  1  one-cycle pulse per status edge.
- o_smp_en  out  1  sample strobe, high for the whole window.
- o_smp_phase  out  1  i_status level that started the current window.
- o_overrun  out  1  one-cycle pulse when a window is cut short.

## Operation
- Reset values:
  - o_freq_cnt = DEF_FREQ; o_amp_H = o_amp_L = 0.
  - All pulses and flags are 0; pending set cleared; active settle = win = 0.
  - status_d = 0; state = IDLE.
- Edge detect:
  - status_d is i_status registered every cycle.
  - edge = (i_status != status_d).
  - fall = edge && !i_status, i.e. HIGH-to-LOW, which is the full-period boundary.
- Configuration:
  - i_cfg_wr copies every field into the pending set and sets o_cfg_pend.
  - A second write before apply overwrites the pending set; last write wins.
  - On fall, with o_cfg_pend set and i_en high:
    - the pending set is copied to the active outputs and active settle/win;
    - o_cfg_pend clears and o_cfg_applied pulses.
  - If i_cfg_wr coincides with that fall, the apply uses the older pending set. The new write then becomes pending and o_cfg_pend stays 1.
  - With i_en low, writes still go to the pending set but are never applied.
- States: IDLE, SETTLE, SAMPLE, WAIT.
  - IDLE: outputs hold. When i_en is high, go to SETTLE on the next edge.
  - SETTLE: counts down the active settle value. At 0, go to SAMPLE if win != 0, otherwise go to WAIT.
  - SAMPLE: o_smp_en is high while counting win cycles, then go to WAIT.
  - WAIT: on the next edge, go to SETTLE.
- Any edge in SETTLE, SAMPLE or WAIT reloads the settle count, latches o_smp_phase = i_status, and restarts in SETTLE.
- Overrun: an edge during SAMPLE drops o_smp_en and pulses o_overrun.
- The settle and win values used are the ones active at the edge. A change applied on the same fall takes effect for that half-period.
- i_en falling:
  - go to IDLE the next cycle and drop o_smp_en;
  - no o_overrun pulse;
  - the active configuration is retained.

## Timing
- Edge cycle E is the cycle whose rising clock first sees i_status != status_d.
- o_sync and o_cfg_applied are registered and high in cycle E+1.
- New o_freq_cnt and o_amp_* values are visible from E+1.
- With settle S and win W > 0, o_smp_en is high for cycles E+1+S through E+S+W inclusive. S = 0 gives first strobe at E+1.
- o_overrun is high at E'+1 for an interrupting edge E'. The o_sync for E' occurs in the same cycle.
- Reset asserted mid-window clears every output asynchronously. After release, state is IDLE until the first edge.
- Counters saturate at 0 and never wrap.

## Structure
- Shared package mod_pkg holds:
  - the state enum {IDLE, SETTLE, SAMPLE, WAIT};
  - the CNT_W default;
  - DEF_FREQ;
  - a cfg_t struct (freq, amp_H, amp_L, settle, win) used for both the pending and active sets.
- One sub-module, mod_cfg_shadow: the pending/active double buffer with its write, apply and coincidence rules. The FSM and counters stay in mod_sched.

## Test plan
- Reset then i_en = 1, no writes, status toggling every 125 cycles:
  - o_freq_cnt = 125, amplitudes 0;
  - o_sync at every E+1;
  - o_smp_en never high (win = 0).
- Write freq = 200, amp_H = 3000, amp_L = -3000, settle = 10, win = 50 mid-HIGH half:
  - o_cfg_pend = 1 until the fall;
  - values appear at fall+1 with o_cfg_applied pulse;
  - first o_smp_en spans E+11..E+60.
- Two writes (amp_H = 100, then amp_H = 200) before one fall: only 200 is applied, with a single o_cfg_applied pulse.
- Write in the exact fall cycle:
  - the previous pending set is applied;
  - o_cfg_pend stays 1;
  - the new set applies at the following fall.
- settle = 5, win = 200, edges 100 cycles apart:
  - o_smp_en runs E+6..E+100;
  - o_overrun pulses at each E'+1;
  - the window restarts with o_smp_phase toggling.
- Assert i_rst_n low during SAMPLE:
  - all outputs return immediately to reset values (o_freq_cnt = 125);
  - after release, no strobe before the first edge.
